// File: rtl/vpu_ub_writer_if.sv
// Handshake bundle between VPU result lanes, tile control and the UB write port.
// The writer sits on the slave side; the master drives lanes, control and UB ready.
interface vpu_ub_writer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic signed [15:0] vpu_data_in_1;
  logic signed [15:0] vpu_data_in_2;
  logic              vpu_valid_in_1;
  logic              vpu_valid_in_2;
  logic              vpu_ready_out_1;
  logic              vpu_ready_out_2;
  logic              ub_wr_en;
  logic [ADDR_W-1:0] ub_wr_addr;
  logic signed [15:0] ub_wr_data;
  logic              ub_wr_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr,
    input  vpu_data_in_1, vpu_data_in_2,
    input  vpu_valid_in_1, vpu_valid_in_2,
    output vpu_ready_out_1, vpu_ready_out_2,
    output ub_wr_en, ub_wr_addr, ub_wr_data,
    input  ub_wr_ready,
    output busy, done
  );

  modport master (
    output start, base_addr,
    output vpu_data_in_1, vpu_data_in_2,
    output vpu_valid_in_1, vpu_valid_in_2,
    input  vpu_ready_out_1, vpu_ready_out_2,
    input  ub_wr_en, ub_wr_addr, ub_wr_data,
    output ub_wr_ready,
    input  busy, done
  );
endinterface

// File: rtl/vpu_ub_writer.sv
// VPU write-back engine: two lane FIFOs round-robin merged onto one UB write port.
// Elements land row-major from the latched base address; done pulses per tile.
module vpu_ub_writer #(
  parameter int B          = 4,
  parameter int D_OUT      = 2,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  vpu_ub_writer_if.slave bus
);
  localparam int COLS = D_OUT / 2;
  localparam int RW   = (B > 1) ? $clog2(B) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int EW   = ADDR_W + 16;
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [RW-1:0]     row_q [2];
  logic [CW-1:0]     col_q [2];
  logic [1:0]        cmp_q;
  logic [EW-1:0]     mem_q [2][FIFO_DEPTH];
  logic [PW-1:0]     wp_q [2];
  logic [PW-1:0]     rp_q [2];
  logic [PW:0]       cnt_q [2];
  logic [PW:0]       cnt_d [2];
  logic              rr_q, gnt_q, lock_q;

  logic [1:0]        vld, rdy, push, pop, ne;
  logic signed [15:0] din [2];
  logic [ADDR_W-1:0] addr [2];
  logic              cand, wr_go, start_ok, drained;
  logic [EW-1:0]     head;

  assign vld      = {bus.vpu_valid_in_2, bus.vpu_valid_in_1};
  assign din[0]   = bus.vpu_data_in_1;
  assign din[1]   = bus.vpu_data_in_2;
  assign start_ok = bus.start && (state_q == S_IDLE);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ne[k]   = cnt_q[k] != '0;
      rdy[k]  = (state_q == S_RUN) && (cnt_q[k] != FULL) && !cmp_q[k];
      push[k] = vld[k] && rdy[k];
      addr[k] = base_q
              + ADDR_W'(row_q[k]) * ADDR_W'(D_OUT)
              + ADDR_W'(col_q[k]) * ADDR_W'(2)
              + ADDR_W'(k);
    end
  end

  // A stalled write keeps its lane even if the preferred lane fills meanwhile.
  always_comb begin
    cand = ne[rr_q] ? rr_q : ~rr_q;
    if (lock_q) cand = gnt_q;
  end

  assign head   = mem_q[cand][rp_q[cand]];
  assign wr_go  = (|ne) && bus.ub_wr_ready;
  assign pop[0] = wr_go && !cand;
  assign pop[1] = wr_go && cand;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k] + (PW+1)'(push[k]) - (PW+1)'(pop[k]);
    end
    drained = (cnt_d[0] == '0) && (cnt_d[1] == '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (&cmp_q) state_d = drained ? S_DONE : S_DRAIN;
      S_DRAIN: if (drained) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cmp_q   <= '0;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      lock_q  <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        row_q[k] <= '0;
        col_q[k] <= '0;
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      lock_q  <= (|ne) && !bus.ub_wr_ready;
      gnt_q   <= cand;
      if (start_ok) begin
        base_q <= bus.base_addr;
        cmp_q  <= '0;
        rr_q   <= 1'b0;
        for (int k = 0; k < 2; k++) begin
          row_q[k] <= '0;
          col_q[k] <= '0;
        end
      end else if (wr_go) begin
        rr_q <= ~cand;
      end
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (pop[k]) rp_q[k] <= rp_q[k] + 1'b1;
        if (push[k]) begin
          wp_q[k] <= wp_q[k] + 1'b1;
          if (row_q[k] == RW'(B-1)) begin
            row_q[k] <= '0;
            if (col_q[k] == CW'(COLS-1)) begin
              col_q[k] <= '0;
              cmp_q[k] <= 1'b1;
            end else begin
              col_q[k] <= col_q[k] + 1'b1;
            end
          end else begin
            row_q[k] <= row_q[k] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem_q[k][wp_q[k]] <= {addr[k], din[k]};
    end
  end

  assign bus.vpu_ready_out_1 = rdy[0];
  assign bus.vpu_ready_out_2 = rdy[1];
  assign bus.ub_wr_en   = |ne;
  assign bus.ub_wr_addr = bus.ub_wr_en ? head[EW-1:16] : '0;
  assign bus.ub_wr_data = bus.ub_wr_en ? head[15:0] : '0;
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_DONE;
endmodule
